exu_md: RTL and testbench

- Parametrised next-generation execute stage: ID/EX pipeline register with hold and flush, 3-way operand forwarding, an extended 10-op ALU, a branch-target adder and an iterative unsigned multiply/divide unit.
- The multiply/divide unit holds the instruction in E for multiple cycles and raises a stall request to the hazard unit.
- Sits between decode and memory stages of the five-stage core.

---
 rtl/exu_md.sv | 227 ++++++++++++++++++++++
 tb/tb_exu_md.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_md.sv
// Execute stage: ID/EX register with hold/flush, operand forwarding, 10-op ALU,
// branch-target adder and an iterative unsigned multiply/divide unit.
module exu_md #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallE,
    input  logic            flushE,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCplus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            ALUSrcD,
    input  logic [3:0]      ALUControlD,
    input  logic            MDValidD,
    input  logic [1:0]      MDOpD,
    input  logic [1:0]      forwardAE,
    input  logic [1:0]      forwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALUResultM,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic [XLEN-1:0] PCplus4E,
    output logic [XLEN-1:0] PCtargetE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] ALUResultE,
    output logic            ZeroE,
    output logic            mdBusyE,
    output logic [1:0]      md_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Handshake with the hazard unit: mdBusyE is a stall request; the E
    // register only advances on a cycle where stallE and mdBusyE are both low.

    // ---------------------------------------------------------------
    // ID/EX pipeline register
    // ---------------------------------------------------------------
    logic [XLEN-1:0] rd1_e, rd2_e, pc_e, imm_e;
    logic            alu_src_e, md_valid_e;
    logic [3:0]      alu_ctrl_e;
    logic [1:0]      md_op_e;
    logic            en_e;

    assign en_e = ~stallE & ~mdBusyE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            pc_e       <= '0;
            PCplus4E   <= '0;
            imm_e      <= '0;
            Rs1E       <= '0;
            Rs2E       <= '0;
            RdE        <= '0;
            alu_src_e  <= 1'b0;
            alu_ctrl_e <= 4'd0;
            md_valid_e <= 1'b0;
            md_op_e    <= 2'd0;
        end else if (flushE) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            pc_e       <= '0;
            PCplus4E   <= '0;
            imm_e      <= '0;
            Rs1E       <= '0;
            Rs2E       <= '0;
            RdE        <= '0;
            alu_src_e  <= 1'b0;
            alu_ctrl_e <= 4'd0;
            md_valid_e <= 1'b0;
            md_op_e    <= 2'd0;
        end else if (en_e) begin
            rd1_e      <= RD1D;
            rd2_e      <= RD2D;
            pc_e       <= PCD;
            PCplus4E   <= PCplus4D;
            imm_e      <= ImmExtD;
            Rs1E       <= Rs1D;
            Rs2E       <= Rs2D;
            RdE        <= RdD;
            alu_src_e  <= ALUSrcD;
            alu_ctrl_e <= ALUControlD;
            md_valid_e <= MDValidD;
            md_op_e    <= MDOpD;
        end
    end

    // ---------------------------------------------------------------
    // Forwarding and ALU
    // ---------------------------------------------------------------
    logic [XLEN-1:0] src_a, src_b, alu_y;
    logic [SHW-1:0]  shamt;

    always_comb begin
        case (forwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = rd1_e;
        endcase
        case (forwardBE)
            2'b01:   WriteDataE = ResultW;
            2'b10:   WriteDataE = ALUResultM;
            default: WriteDataE = rd2_e;
        endcase
    end

    assign src_b     = alu_src_e ? imm_e : WriteDataE;
    assign shamt     = src_b[SHW-1:0];
    assign PCtargetE = pc_e + imm_e;

    always_comb begin
        alu_y = '0;
        case (alu_ctrl_e)
            4'd0: alu_y = src_a + src_b;
            4'd1: alu_y = src_a - src_b;
            4'd2: alu_y = src_a & src_b;
            4'd3: alu_y = src_a | src_b;
            4'd4: alu_y = src_a ^ src_b;
            4'd5: alu_y = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd6: alu_y = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'd7: alu_y = src_a << shamt;
            4'd8: alu_y = src_a >> shamt;
            4'd9: alu_y = $signed(src_a) >>> shamt;
            default: alu_y = '0;
        endcase
    end

    // ---------------------------------------------------------------
    // Multiply/divide FSM
    // ---------------------------------------------------------------
    md_state_e state_q, state_d;
    logic      is_div, div_by_zero, last_step;
    logic [SHW:0] cnt;

    assign is_div      = md_op_e[1];
    assign div_by_zero = is_div && (WriteDataE == '0);
    assign last_step   = (cnt == (SHW+1)'(XLEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flushE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (md_valid_e) state_d = div_by_zero ? DONE : RUN;
                RUN:     if (last_step) state_d = DONE;
                DONE:    if (!stallE) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign mdBusyE  = md_valid_e && (state_q != DONE);
    assign md_state = state_q;

    // hi/lo hold {product high, product low} for multiply and
    // {remainder, quotient} for divide; op_b is multiplicand or divisor.
    logic [XLEN-1:0] hi, lo, op_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;

    assign mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? op_b : {XLEN{1'b0}})};
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, op_b});
    assign div_rem   = div_ge ? (div_shift[XLEN-1:0] - op_b) : div_shift[XLEN-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi   <= '0;
            lo   <= '0;
            op_b <= '0;
            cnt  <= '0;
        end else if (!flushE) begin
            if (state_q == IDLE && md_valid_e) begin
                cnt <= '0;
                if (div_by_zero) begin
                    hi <= src_a;
                    lo <= '1;
                end else if (is_div) begin
                    hi   <= '0;
                    lo   <= src_a;
                    op_b <= WriteDataE;
                end else begin
                    hi   <= '0;
                    lo   <= WriteDataE;
                    op_b <= src_a;
                end
            end else if (state_q == RUN) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    hi <= div_rem;
                    lo <= {lo[XLEN-2:0], div_ge};
                end else begin
                    hi <= mul_sum[XLEN:1];
                    lo <= {mul_sum[0], lo[XLEN-1:1]};
                end
            end
        end
    end

    // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half.
    assign ALUResultE = md_valid_e ? (md_op_e[0] ? hi : lo) : alu_y;
    assign ZeroE      = (ALUResultE == '0);

endmodule

// File: tb/tb_exu_md.sv
// Self-checking bench for exu_md: directed and random ALU/MD traffic
// through a result scoreboard, plus flush, stall and async-reset cases.
module tb_exu_md;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            stallE, flushE;
    logic [XLEN-1:0] RD1D, RD2D, PCD, PCplus4D, ImmExtD;
    logic [REGW-1:0] Rs1D, Rs2D, RdD;
    logic            ALUSrcD;
    logic [3:0]      ALUControlD;
    logic            MDValidD;
    logic [1:0]      MDOpD;
    logic [1:0]      forwardAE, forwardBE;
    logic [XLEN-1:0] ResultW, ALUResultM;
    logic [REGW-1:0] Rs1E, Rs2E, RdE;
    logic [XLEN-1:0] PCplus4E, PCtargetE, WriteDataE, ALUResultE;
    logic            ZeroE, mdBusyE;
    logic [1:0]      md_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [XLEN-1:0] exp_q[$];

    exu_md #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCplus4D(PCplus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .MDValidD(MDValidD), .MDOpD(MDOpD), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .ResultW(ResultW), .ALUResultM(ALUResultM),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCplus4E(PCplus4E), .PCtargetE(PCtargetE),
        .WriteDataE(WriteDataE), .ALUResultE(ALUResultE), .ZeroE(ZeroE), .mdBusyE(mdBusyE),
        .md_state(md_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [XLEN-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, ALUResultE, e);
        end
    endtask

    function automatic logic [XLEN-1:0] alu_model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            4'd9: return $signed(a) >>> b[4:0];
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] md_model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0: return p[XLEN-1:0];
            2'd1: return p[2*XLEN-1:XLEN];
            2'd2: return (b == 0) ? '1 : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // driver tasks
    task automatic load();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                           input logic src, input logic [3:0] op, input logic md, input logic [1:0] mdop,
                           input logic [REGW-1:0] rd);
        RD1D        = a;
        RD2D        = b;
        ImmExtD     = imm;
        ALUSrcD     = src;
        ALUControlD = op;
        MDValidD    = md;
        MDOpD       = mdop;
        RdD         = rd;
        Rs1D        = REGW'($urandom_range(0, 31));
        Rs2D        = REGW'($urandom_range(0, 31));
        PCD         = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
        PCplus4D    = PCD + 32'd4;
    endtask

    task automatic alu_op(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] imm, input logic src, input logic [3:0] op);
        drive_d(a, b, imm, src, op, 1'b0, 2'd0, 5'd1);
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        exp_q.push_back(alu_model(op, a, src ? imm : b));
        load();
        sb_check(tag);
    endtask

    // Issues an MD op and waits (bounded) until the stall request drops.
    task automatic md_op(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic chk_busy);
        int busy;
        drive_d(a, b, 32'd0, 1'b0, 4'd0, 1'b1, op, 5'd5);
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        exp_q.push_back(md_model(op, a, b));
        load();
        busy = 0;
        while (mdBusyE && busy < 200) begin
            busy++;
            load();
        end
        if (chk_busy) check_eq({tag, "_busy_cycles"}, busy, XLEN + 1);
        check_eq({tag, "_done_state"}, md_state, 2'd2);
        sb_check(tag);
    endtask

    initial begin
        logic [XLEN-1:0] a, b, imm;
        logic [3:0]      op;
        logic [1:0]      mop;
        logic            src;
        logic [XLEN-1:0] held;

        // reset block
        reset = 1'b0;
        stallE = 1'b0; flushE = 1'b0;
        forwardAE = 2'b00; forwardBE = 2'b00;
        ResultW = '0; ALUResultM = '0;
        drive_d('0, '0, '0, 1'b0, 4'd0, 1'b0, 2'd0, 5'd0);
        repeat (2) load();
        check_eq("rst_alu", ALUResultE, 32'd0);
        check_eq("rst_zero", ZeroE, 1'b1);
        check_eq("rst_busy", mdBusyE, 1'b0);
        check_eq("rst_rd", RdE, 5'd0);
        check_eq("rst_pc4", PCplus4E, 32'd0);
        check_eq("rst_state", md_state, 2'd0);
        reset = 1'b1;

        // forwarding from M into A
        drive_d(32'd5, 32'd3, 32'h20, 1'b0, 4'd0, 1'b0, 2'd0, 5'd7);
        PCD = 32'h1000; PCplus4D = 32'h1004;
        forwardAE = 2'b10; ALUResultM = 32'h10;
        exp_q.push_back(32'h13);
        load();
        sb_check("fwd_m_add");
        check_eq("fwd_m_zero", ZeroE, 1'b0);
        check_eq("fwd_m_busy", mdBusyE, 1'b0);
        check_eq("fwd_m_wdata", WriteDataE, 32'd3);
        check_eq("pc_target", PCtargetE, 32'h1020);
        check_eq("pc_plus4", PCplus4E, 32'h1004);
        check_eq("rd_e", RdE, 5'd7);

        // forwarding from W into B (store data follows forwarding)
        drive_d(32'd1, 32'd99, 32'd0, 1'b0, 4'd0, 1'b0, 2'd0, 5'd2);
        forwardAE = 2'b00; forwardBE = 2'b01; ResultW = 32'h20;
        exp_q.push_back(32'h21);
        load();
        sb_check("fwd_w_add");
        check_eq("fwd_w_wdata", WriteDataE, 32'h20);
        forwardBE = 2'b11;
        #1;
        check_eq("fwd_11_wdata", WriteDataE, 32'd99);

        // directed ALU corners
        alu_op("sub_zero", 32'd7, 32'd7, 32'd0, 1'b0, 4'd1);
        check_eq("sub_zero_flag", ZeroE, 1'b1);
        alu_op("sra_imm", 32'h8000_0000, 32'd0, 32'd4, 1'b1, 4'd9);
        alu_op("srl_imm", 32'h8000_0000, 32'd0, 32'd4, 1'b1, 4'd8);
        alu_op("sll_imm", 32'h8000_0001, 32'd0, 32'd4, 1'b1, 4'd7);
        alu_op("slt_neg", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'd5);
        alu_op("sltu_big", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'd6);
        alu_op("add_wrap", 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'd0);
        alu_op("op_12", 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 4'd12);

        // random ALU traffic
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            b   = $urandom;
            imm = $urandom;
            src = 1'($urandom_range(0, 1));
            op  = 4'($urandom_range(0, 15));
            alu_op($sformatf("rnd_alu_%0d_op%0d", i, op), a, b, imm, src, op);
        end

        // multiply/divide, back to back
        md_op("mulhu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        md_op("mul_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        md_op("divu_100_7", 2'd2, 32'd100, 32'd7, 1'b1);
        md_op("remu_100_7", 2'd3, 32'd100, 32'd7, 1'b1);
        md_op("divu_by0", 2'd2, 32'd9, 32'd0, 1'b0);
        md_op("remu_by0", 2'd3, 32'd9, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            mop = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            md_op($sformatf("rnd_md_%0d_op%0d", i, mop), mop, a, b, 1'b1);
        end

        // DONE result held under external stall, then next instruction loads
        md_op("mul_6_7", 2'd0, 32'd6, 32'd7, 1'b1);
        held = ALUResultE;
        stallE = 1'b1;
        drive_d(32'd1, 32'd2, 32'd0, 1'b0, 4'd0, 1'b0, 2'd0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            load();
            check_eq($sformatf("stall_hold_%0d", i), ALUResultE, 32'd42);
            check_eq($sformatf("stall_rd_%0d", i), RdE, 5'd5);
            check_eq($sformatf("stall_state_%0d", i), md_state, 2'd2);
        end
        check_eq("stall_held_eq", ALUResultE, held);
        stallE = 1'b0;
        exp_q.push_back(32'd3);
        load();
        sb_check("stall_release");
        check_eq("stall_release_rd", RdE, 5'd9);

        // flush at RUN cycle 10 leaves a bubble
        drive_d(32'd100, 32'd7, 32'd0, 1'b0, 4'd0, 1'b1, 2'd2, 5'd6);
        load();
        repeat (10) load();
        check_eq("flush_pre_busy", mdBusyE, 1'b1);
        check_eq("flush_pre_state", md_state, 2'd1);
        flushE = 1'b1;
        exp_q.push_back(32'd0);
        load();
        flushE = 1'b0;
        sb_check("flush_bubble");
        check_eq("flush_busy", mdBusyE, 1'b0);
        check_eq("flush_state", md_state, 2'd0);
        check_eq("flush_rd", RdE, 5'd0);

        // MD works again after a flush
        md_op("post_flush_divu", 2'd2, 32'd1000, 32'd33, 1'b1);

        // asynchronous reset mid-RUN, observed before any clock edge
        drive_d(32'h1234_5678, 32'h9ABC_DEF1, 32'h40, 1'b0, 4'd0, 1'b1, 2'd1, 5'd11);
        load();
        repeat (5) load();
        check_eq("arst_pre_busy", mdBusyE, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_busy", mdBusyE, 1'b0);
        check_eq("arst_alu", ALUResultE, 32'd0);
        check_eq("arst_zero", ZeroE, 1'b1);
        check_eq("arst_rd", RdE, 5'd0);
        check_eq("arst_pc4", PCplus4E, 32'd0);
        check_eq("arst_target", PCtargetE, 32'd0);
        check_eq("arst_wdata", WriteDataE, 32'd0);
        check_eq("arst_state", md_state, 2'd0);
        reset = 1'b1;
        alu_op("post_reset_xor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 4'd4);

        check_eq("sb_drained", exp_q.size(), 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
